// File: rtl/muldiv_unit.sv
// Execute-stage multiply/divide unit with private HI/LO registers.
// Results are computed at acceptance and committed after a fixed busy window.
module muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        cancel,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    logic [CNT_W-1:0] cnt;
    logic [63:0]      pend;
    logic             pend_wr;

    logic [31:0] a_mag, b_mag, b_div_s, b_div_u;
    logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;
    logic [63:0] prod_s, prod_u;

    // Signed divide works on magnitudes so 0x80000000 / -1 yields 0x80000000 with no overflow trap.
    always_comb begin
        a_mag   = A[31] ? (~A + 32'd1) : A;
        b_mag   = B[31] ? (~B + 32'd1) : B;
        b_div_s = (b_mag == 32'd0) ? 32'd1 : b_mag;
        b_div_u = (B == 32'd0) ? 32'd1 : B;
        q_mag   = a_mag / b_div_s;
        r_mag   = a_mag % b_div_s;
        q_s     = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
        r_s     = A[31] ? (~r_mag + 32'd1) : r_mag;
        q_u     = A / b_div_u;
        r_u     = A % b_div_u;
        prod_s  = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u  = {32'd0, A} * {32'd0, B};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy    <= 1'b0;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            pend    <= '0;
            pend_wr <= 1'b0;
        end else if (busy) begin
            if (cnt == '0) begin
                busy <= 1'b0;
                if (pend_wr) {hi, lo} <= pend;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end else if (start && !cancel) begin
            case (op)
                OP_MULT: begin
                    pend <= prod_s; pend_wr <= 1'b1;
                    busy <= 1'b1;   cnt <= CNT_W'(MULT_CYCLES - 1);
                end
                OP_MULTU: begin
                    pend <= prod_u; pend_wr <= 1'b1;
                    busy <= 1'b1;   cnt <= CNT_W'(MULT_CYCLES - 1);
                end
                OP_DIV: begin
                    // Divide by zero still occupies the unit but leaves HI/LO untouched.
                    pend <= {r_s, q_s}; pend_wr <= (B != 32'd0);
                    busy <= 1'b1;       cnt <= CNT_W'(DIV_CYCLES - 1);
                end
                OP_DIVU: begin
                    pend <= {r_u, q_u}; pend_wr <= (B != 32'd0);
                    busy <= 1'b1;       cnt <= CNT_W'(DIV_CYCLES - 1);
                end
                OP_MTHI: hi <= A;
                OP_MTLO: lo <= A;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with hand-computed vectors.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic        cancel;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_err = 0;

    muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .cancel(cancel),
        .A(A), .B(B), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs and samples settle 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; A = a; B = b;
        step();
        start = 1'b0; op = 3'd7; A = '0; B = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; op = 3'd7; cancel = 1'b0; A = '0; B = '0;
        step(); step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
                n_err++;
                $display("FAIL reset_idle[%0d]: got busy=%b hi=%h lo=%h want 0/0/0", i, busy, hi, lo);
            end
        end
    endtask

    task automatic test_mthi_mtlo();
        start = 1'b1; op = 3'd4; A = 32'hDEADBEEF;
        step();
        n_cmp++;
        if (hi !== 32'hDEADBEEF || busy !== 1'b0) begin
            n_err++;
            $display("FAIL mthi: got hi=%h busy=%b want deadbeef/0", hi, busy);
        end
        op = 3'd5; A = 32'd1;
        step();
        start = 1'b0; op = 3'd7; A = '0;
        n_cmp++;
        if (lo !== 32'd1 || hi !== 32'hDEADBEEF || busy !== 1'b0) begin
            n_err++;
            $display("FAIL mtlo: got hi=%h lo=%h busy=%b want deadbeef/1/0", hi, lo, busy);
        end
    endtask

    task automatic test_mult();
        logic [31:0] old_hi, old_lo;
        old_hi = 32'hDEADBEEF; old_lo = 32'd1;
        issue(3'd0, 32'hFFFFFFFE, 32'd3);
        for (int i = 1; i <= 5; i++) begin
            n_cmp++;
            if (busy !== 1'b1 || hi !== old_hi || lo !== old_lo) begin
                n_err++;
                $display("FAIL mult_busy[t+%0d]: got busy=%b hi=%h lo=%h want 1/%h/%h", i, busy, hi, lo, old_hi, old_lo);
            end
            step();
        end
        n_cmp++;
        if (busy !== 1'b0 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
            n_err++;
            $display("FAIL mult_result: got busy=%b hi=%h lo=%h want 0/ffffffff/fffffffa", busy, hi, lo);
        end
        issue(3'd1, 32'hFFFFFFFE, 32'd3);
        for (int i = 1; i <= 5; i++) begin
            n_cmp++;
            if (busy !== 1'b1 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
                n_err++;
                $display("FAIL multu_busy[t+%0d]: got busy=%b hi=%h lo=%h", i, busy, hi, lo);
            end
            step();
        end
        n_cmp++;
        if (busy !== 1'b0 || hi !== 32'h00000002 || lo !== 32'hFFFFFFFA) begin
            n_err++;
            $display("FAIL multu_result: got busy=%b hi=%h lo=%h want 0/00000002/fffffffa", busy, hi, lo);
        end
    endtask

    task automatic test_div();
        int nbusy;
        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        nbusy = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy === 1'b1) nbusy++;
            step();
        end
        n_cmp++;
        if (nbusy != 10 || busy !== 1'b0 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            n_err++;
            $display("FAIL div_signed: got busycycles=%0d busy=%b hi=%h lo=%h want 10/0/ffffffff/fffffffd", nbusy, busy, hi, lo);
        end
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        for (int i = 0; i < 10; i++) step();
        n_cmp++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'h80000000) begin
            n_err++;
            $display("FAIL div_overflow: got busy=%b hi=%h lo=%h want 0/00000000/80000000", busy, hi, lo);
        end
        issue(3'd4, 32'h11, 32'd0);
        issue(3'd5, 32'h22, 32'd0);
        issue(3'd3, 32'd7, 32'd0);
        nbusy = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy === 1'b1) nbusy++;
            step();
        end
        n_cmp++;
        if (nbusy != 10 || busy !== 1'b0 || hi !== 32'h11 || lo !== 32'h22) begin
            n_err++;
            $display("FAIL divu_by_zero: got busycycles=%0d busy=%b hi=%h lo=%h want 10/0/11/22", nbusy, busy, hi, lo);
        end
    endtask

    task automatic test_cancel();
        cancel = 1'b1;
        issue(3'd0, 32'd9, 32'd9);
        cancel = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (busy !== 1'b0 || hi !== 32'h11 || lo !== 32'h22) begin
                n_err++;
                $display("FAIL cancel[%0d]: got busy=%b hi=%h lo=%h want 0/11/22", i, busy, hi, lo);
            end
            step();
        end
        issue(3'd6, 32'd5, 32'd5);
        n_cmp++;
        if (busy !== 1'b0 || hi !== 32'h11 || lo !== 32'h22) begin
            n_err++;
            $display("FAIL op_nop: got busy=%b hi=%h lo=%h want 0/11/22", busy, hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        issue(3'd0, 32'd3, 32'd5);
        step();
        issue(3'd0, 32'd2, 32'd2);
        for (int i = 0; i < 3; i++) step();
        n_cmp++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd15) begin
            n_err++;
            $display("FAIL start_while_busy: got busy=%b hi=%h lo=%h want 0/0/f", busy, hi, lo);
        end
        step();
        n_cmp++;
        if (busy !== 1'b0 || lo !== 32'd15) begin
            n_err++;
            $display("FAIL start_while_busy_after: got busy=%b lo=%h want 0/f", busy, lo);
        end
    endtask

    task automatic test_reset_mid_op();
        issue(3'd1, 32'h00010000, 32'h00010000);
        step(); step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        n_cmp++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_err++;
            $display("FAIL reset_mid: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++;
            if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
                n_err++;
                $display("FAIL reset_no_late_write[%0d]: got busy=%b hi=%h lo=%h want 0/0/0", i, busy, hi, lo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mthi_mtlo();
        test_mult();
        test_div();
        test_cancel();
        test_back_to_back();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Execute-stage multiply/divide unit with its own HI/LO register pair.
- Operands arrive already forwarded: the E-stage RS/RT mux outputs, selected by the forwarding unit's ForwardRS_E/ForwardRT_E.
- Provides a multi-cycle busy window that the hazard/stall logic uses to hold younger MULT/DIV/MFHI/MFLO/MTHI/MTLO in D.
- Provides current HI/LO to the E-stage result mux for MFHI/MFLO.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for MULT/MULTU (≥1).
- DIV_CYCLES, 10, busy duration in cycles for DIV/DIVU (≥1).

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- reset, input, 1, synchronous active-low reset (sampled on rising edge of clk; 0 = reset).
- start, input, 1, E-stage instruction is a mult/div-class op this cycle.
- op, input, 3, 0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6/7 = no-op.
- cancel, input, 1, exception/flush in M or later this cycle; blocks acceptance of start.
- A, input, 32, forwarded RS operand.
- B, input, 32, forwarded RT operand.
- busy, output, 1, operation in progress; registered.
- hi, output, 32, current HI register.
- lo, output, 32, current LO register.

Behaviour:
- Reset (reset==0 at an edge):
  - hi=0, lo=0, busy=0; cycle counter=0; pending result discarded.
  - Reset takes priority over everything, including mid-operation.
- Acceptance: start && !cancel && !busy && op in {0..5} at edge t.
  - start while busy is ignored. The hazard unit prevents this; no queueing.
- MTHI/MTLO:
  - hi<=A (or lo<=A) at edge t, visible at t+1.
  - busy stays 0; no counter activity.
- MULT/MULTU/DIV/DIVU:
  - At edge t: latch the full 64-bit result into pending regs, busy<=1, counter<=N-1 (N=MULT_CYCLES or DIV_CYCLES).
  - Each busy edge: counter decrements. At the edge where counter==0: hi/lo<=pending, busy<=0.
  - busy is high for exactly N cycles (t+1..t+N). New hi/lo visible at cycle t+N+1, the same cycle busy reads 0.
  - hi/lo hold their old values throughout the busy window.
- Arithmetic:
  - MULT: signed 32x32 -> 64; hi=upper 32 bits, lo=lower 32 bits.
  - MULTU: unsigned 32x32 -> 64; same split.
  - DIV: signed, quotient truncated toward zero -> lo; remainder takes sign of dividend -> hi.
  - DIVU: unsigned; quotient -> lo, remainder -> hi.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (no trap).
  - Divide by zero (B==0): still busy DIV_CYCLES; hi/lo unchanged at completion.
- cancel:
  - Only gates acceptance in the cycle start is presented.
  - An operation already accepted is never aborted by cancel; only reset aborts it.
- op 6/7 with start: no effect.
- Stall contract for hazard logic:
  - Stall D if a mult/div-class op is in D and (busy || start accepted this cycle).
- Outputs hi/lo/busy are driven directly from registers; no combinational path from inputs.

Test Plan:
- Reset then idle: hold reset=0 two cycles, release -> hi=0, lo=0, busy=0 every cycle thereafter.
- MULT, A=0xFFFFFFFE (-2), B=3, start at t -> busy=1 for cycles t+1..t+5; at t+6: hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0. Repeat with MULTU -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV, A=-7 (0xFFFFFFF9), B=2 -> busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU, A=7, B=0 with prior hi=0x11, lo=0x22 -> after 10 busy cycles: hi=0x11, lo=0x22.
- MTHI A=0xDEADBEEF at t -> hi=0xDEADBEEF at t+1, busy never asserts. Next cycle MTLO A=1 -> lo=1.
- start with op=MULT and cancel=1 -> busy stays 0, hi/lo unchanged. start during busy (second MULT, A=B=2) -> ignored; first result lands unchanged.
- MULT accepted, reset=0 at busy cycle 3 -> next cycle busy=0, hi=lo=0; after release, no late write of the pending product.
